fifo_rd_seq: RTL and testbench

- Read-side sequencer for the async FIFO; lives entirely in the read clock domain.
- Drives rinc into the FIFO read-pointer logic and captures FIFO read data into a 2-entry output buffer.
- Presents buffered data downstream on a valid/ready handshake.
- Two modes: continuous streaming, or fixed-length bursts with a completion pulse.

---
 rtl/fifo_rd_seq_pkg.sv | 26 ++
 rtl/fifo_rd_seq_if.sv | 32 +++
 rtl/fifo_rd_skid2.sv | 55 +++++
 rtl/fifo_rd_seq.sv | 120 ++++++++++++
 tb/tb_fifo_rd_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_seq_pkg.sv
// Shared definitions for the async-FIFO read-side sequencer: state
// encoding, burst length width and the burst length decode.
package fifo_rd_seq_pkg;

  localparam int BURST_LEN_W = 4;
  localparam int REM_W       = BURST_LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    BURST  = 2'd2,
    DONE   = 2'd3
  } rd_state_e;

  // A burst length field of zero stands for the maximum burst of 16 words.
  function automatic logic [REM_W-1:0] burst_len_decode(input logic [BURST_LEN_W-1:0] len);
    logic [REM_W-1:0] words;
    if (len == 4'd0) begin
      words = 5'd16;
    end else begin
      words = {1'b0, len};
    end
    return words;
  endfunction

endpackage

// File: rtl/fifo_rd_seq_if.sv
// Bundle of FIFO-side, control and downstream signals of the read sequencer.
// master = the sequencer itself, slave = FIFO logic plus downstream consumer.
interface fifo_rd_seq_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  import fifo_rd_seq_pkg::*;

  logic                   rempty;
  logic [DATA_W-1:0]      rdata;
  logic                   rinc;
  logic                   stream_en;
  logic                   burst_start;
  logic [BURST_LEN_W-1:0] burst_len;
  logic [DATA_W-1:0]      dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   busy;
  logic                   burst_done;
  logic [CNT_W-1:0]       pop_count;

  modport master (
    input  rempty, rdata, stream_en, burst_start, burst_len, dout_ready,
    output rinc, dout, dout_valid, busy, burst_done, pop_count
  );

  modport slave (
    output rempty, rdata, stream_en, burst_start, burst_len, dout_ready,
    input  rinc, dout, dout_valid, busy, burst_done, pop_count
  );

endinterface

// File: rtl/fifo_rd_skid2.sv
// Two-entry output buffer. A push and a pop in the same cycle at full
// occupancy is legal: the freed head slot is the one being overwritten.
module fifo_rd_skid2 #(
  parameter int DATA_W = 8
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem_r [0:1];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        occ_r;
  logic              pop_s;
  logic              push_s;

  // Qualify pop/push so an empty pop or an overflowing push can never corrupt state.
  always_comb begin
    pop_s  = pop & (occ_r != 2'd0);
    push_s = push & ((occ_r != 2'd2) | pop_s);
  end

  // Storage, pointers and occupancy; reset clears data so head reads zero.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      mem_r[0] <= {DATA_W{1'b0}};
      mem_r[1] <= {DATA_W{1'b0}};
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign head = mem_r[rd_ptr_r];
  assign occ  = occ_r;

endmodule

// File: rtl/fifo_rd_seq.sv
// Read-domain sequencer: pops the async FIFO (rinc), buffers words in a
// two-entry skid buffer and serves them on a valid/ready port, either as a
// continuous stream or as fixed-length bursts ending in a done pulse.
module fifo_rd_seq
  import fifo_rd_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic           rclk,
  input logic           rrst,
  fifo_rd_seq_if.master bus
);

  rd_state_e         state_r;
  logic [REM_W-1:0]  remaining_r;
  logic [CNT_W-1:0]  pop_count_r;
  logic              busy_r;
  logic              burst_done_r;

  logic [1:0]        occ_s;
  logic [DATA_W-1:0] head_s;
  logic              dout_valid_s;
  logic              drain_s;
  logic              space_s;
  logic              pop_ok_s;
  logic              rinc_s;

  // Pop request: only when the mode allows it, the FIFO has data and the buffer has room.
  always_comb begin
    dout_valid_s = (occ_s != 2'd0);
    drain_s      = dout_valid_s & bus.dout_ready;
    space_s      = (occ_s < 2'd2) | drain_s;
    pop_ok_s     = (state_r == STREAM) |
                   ((state_r == BURST) & (remaining_r != {REM_W{1'b0}}));
    rinc_s       = pop_ok_s & ~bus.rempty & space_s;
  end

  fifo_rd_skid2 #(.DATA_W(DATA_W)) u_skid (
    .rclk      (rclk),
    .rrst      (rrst),
    .push      (rinc_s),
    .push_data (bus.rdata),
    .pop       (drain_s),
    .head      (head_s),
    .occ       (occ_s)
  );

  // Mode FSM with burst word counter, registered busy and done pulse.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_r      <= IDLE;
      remaining_r  <= {REM_W{1'b0}};
      busy_r       <= 1'b0;
      burst_done_r <= 1'b0;
    end else begin
      burst_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.burst_start) begin
            state_r     <= BURST;
            remaining_r <= burst_len_decode(bus.burst_len);
            busy_r      <= 1'b1;
          end else if (bus.stream_en) begin
            state_r <= STREAM;
            busy_r  <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        STREAM: begin
          if (!bus.stream_en) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
        BURST: begin
          if (rinc_s) begin
            remaining_r <= remaining_r - 5'd1;
          end
          // Finish only once every burst word has also left the buffer.
          if ((remaining_r == {REM_W{1'b0}}) && (occ_s == 2'd0)) begin
            state_r      <= DONE;
            burst_done_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          remaining_r <= {REM_W{1'b0}};
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Running count of popped words; wraps naturally.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pop_count_r <= {CNT_W{1'b0}};
    end else if (rinc_s) begin
      pop_count_r <= pop_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pop_count_r <= pop_count_r;
    end
  end

  assign bus.rinc       = rinc_s;
  assign bus.dout       = head_s;
  assign bus.dout_valid = dout_valid_s;
  assign bus.busy       = busy_r;
  assign bus.burst_done = burst_done_r;
  assign bus.pop_count  = pop_count_r;

endmodule

// File: tb/tb_fifo_rd_seq.sv
// Directed testbench for fifo_rd_seq: a simple array models the async FIFO
// read side, inputs change and outputs are sampled on the falling edge.
module tb_fifo_rd_seq;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic rclk;
  logic rrst;

  fifo_rd_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fifo_rd_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  logic [7:0] fmem  [0:255];
  logic [7:0] rd_idx = 8'd0;
  logic [7:0] wr_idx = 8'd0;
  logic [7:0] acc   [0:255];
  int         acc_n = 0;
  logic [7:0] exp_w [0:255];
  int         exp_n;
  int         n_pass;
  int         n_tot;

  // Free-running read clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  assign bus.rempty = (rd_idx == wr_idx);
  assign bus.rdata  = fmem[rd_idx];

  // FIFO model read pointer follows the popped words.
  always @(posedge rclk) begin
    if (bus.rinc) rd_idx <= rd_idx + 8'd1;
  end

  // Log every word accepted downstream, for the final order check.
  always @(posedge rclk) begin
    if (!rrst && bus.dout_valid && bus.dout_ready) begin
      acc[acc_n] <= bus.dout;
      acc_n      <= acc_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic push(input logic [7:0] w);
    fmem[wr_idx]  = w;
    exp_w[exp_n]  = w;
    exp_n++;
    wr_idx = wr_idx + 8'd1;
  endtask

  initial begin
    logic [6:0] e_rinc, e_valid, e_done, e_busy;
    int pops, done_n, done_c, bad;

    n_pass = 0; n_tot = 0; exp_n = 0;
    rrst = 1'b1;
    bus.stream_en = 1'b0; bus.burst_start = 1'b0;
    bus.burst_len = 4'd0; bus.dout_ready = 1'b0;
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);

    // Reset / idle state
    check("rst_rinc", 32'(bus.rinc), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_popcnt", 32'(bus.pop_count), 32'd0);
    check("rst_done", 32'(bus.burst_done), 32'd0);

    // Streaming throughput: 0x10..0x17, one word per cycle
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    bus.dout_ready = 1'b1;
    bus.stream_en  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge rclk);
      check("stream_rinc", 32'(bus.rinc), (i < 8) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check("stream_dout", 32'(bus.dout), 32'h10 + 32'(i - 1));
        check("stream_valid", 32'(bus.dout_valid), 32'd1);
      end
    end
    @(negedge rclk);
    check("stream_drained", 32'(bus.dout_valid), 32'd0);
    check("stream_popcnt", 32'(bus.pop_count), 32'd8);
    check("stream_busy", 32'(bus.busy), 32'd1);
    bus.stream_en = 1'b0;
    @(negedge rclk);
    check("stream_off_busy", 32'(bus.busy), 32'd0);
    check("stream_off_rinc", 32'(bus.rinc), 32'd0);

    // Burst of 3 with 5 words available
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    e_rinc  = 7'b0000111;
    e_valid = 7'b0001110;
    e_done  = 7'b0100000;
    e_busy  = 7'b0111111;
    bus.burst_len   = 4'd3;
    bus.burst_start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge rclk);
      if (c == 0) bus.burst_start = 1'b0;
      check("b3_rinc", 32'(bus.rinc), 32'(e_rinc[c]));
      check("b3_valid", 32'(bus.dout_valid), 32'(e_valid[c]));
      check("b3_done", 32'(bus.burst_done), 32'(e_done[c]));
      check("b3_busy", 32'(bus.busy), 32'(e_busy[c]));
      if (e_valid[c]) check("b3_dout", 32'(bus.dout), 32'h20 + 32'(c - 1));
    end
    check("b3_fifo_left", 32'(wr_idx - rd_idx), 32'd2);
    check("b3_popcnt", 32'(bus.pop_count), 32'd11);

    // burst_len=0 means 16 words; 20 words available
    for (int i = 0; i < 18; i++) push(8'h30 + 8'(i));
    bus.burst_len   = 4'd0;
    bus.burst_start = 1'b1;
    pops = 0; done_n = 0; done_c = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge rclk);
      if (c == 1) bus.burst_start = 1'b0;
      if (bus.rinc) pops++;
      if (bus.burst_done) begin
        done_n++;
        done_c = c;
      end
    end
    check("b16_pops", 32'(pops), 32'd16);
    check("b16_done_cnt", 32'(done_n), 32'd1);
    check("b16_done_cycle", 32'(done_c), 32'd19);
    check("b16_fifo_left", 32'(wr_idx - rd_idx), 32'd4);
    check("b16_popcnt", 32'(bus.pop_count), 32'd27);
    check("b16_busy", 32'(bus.busy), 32'd0);

    // Back-pressure: remaining words 0x3E..0x41 streamed with ready low
    bus.dout_ready = 1'b0;
    bus.stream_en  = 1'b1;
    @(negedge rclk);
    check("bp_rinc1", 32'(bus.rinc), 32'd1);
    @(negedge rclk);
    check("bp_rinc2", 32'(bus.rinc), 32'd1);
    check("bp_dout2", 32'(bus.dout), 32'h3E);
    for (int c = 3; c <= 5; c++) begin
      @(negedge rclk);
      check("bp_hold_rinc", 32'(bus.rinc), 32'd0);
      check("bp_hold_dout", 32'(bus.dout), 32'h3E);
      check("bp_hold_valid", 32'(bus.dout_valid), 32'd1);
    end
    bus.dout_ready = 1'b1;
    #1;
    check("bp_release_rinc", 32'(bus.rinc), 32'd1);
    @(negedge rclk);
    check("bp_dout6", 32'(bus.dout), 32'h3F);
    check("bp_rinc6", 32'(bus.rinc), 32'd1);
    @(negedge rclk);
    check("bp_dout7", 32'(bus.dout), 32'h40);
    check("bp_rinc7", 32'(bus.rinc), 32'd0);
    @(negedge rclk);
    check("bp_dout8", 32'(bus.dout), 32'h41);
    @(negedge rclk);
    check("bp_empty", 32'(bus.dout_valid), 32'd0);
    check("bp_popcnt", 32'(bus.pop_count), 32'd31);
    bus.stream_en = 1'b0;
    @(negedge rclk);

    // Empty stall mid-burst plus an ignored burst_start
    push(8'h50);
    push(8'h51);
    bus.burst_len   = 4'd4;
    bus.burst_start = 1'b1;
    @(negedge rclk);
    bus.burst_start = 1'b0;
    check("st_rinc1", 32'(bus.rinc), 32'd1);
    check("st_busy1", 32'(bus.busy), 32'd1);
    @(negedge rclk);
    check("st_rinc2", 32'(bus.rinc), 32'd1);
    @(negedge rclk);
    check("st_rinc3", 32'(bus.rinc), 32'd0);
    check("st_busy3", 32'(bus.busy), 32'd1);
    @(negedge rclk);
    bus.burst_start = 1'b1;
    bus.burst_len   = 4'd1;
    check("st_rinc4", 32'(bus.rinc), 32'd0);
    @(negedge rclk);
    bus.burst_start = 1'b0;
    check("st_rinc5", 32'(bus.rinc), 32'd0);
    check("st_busy5", 32'(bus.busy), 32'd1);
    @(negedge rclk);
    check("st_rinc6", 32'(bus.rinc), 32'd0);
    check("st_done6", 32'(bus.burst_done), 32'd0);
    push(8'h52);
    push(8'h53);
    #1;
    check("st_resume_rinc", 32'(bus.rinc), 32'd1);
    pops = 0; done_n = 0; done_c = 0;
    for (int c = 7; c <= 30; c++) begin
      @(negedge rclk);
      if (bus.rinc) pops++;
      if (bus.burst_done) begin
        done_n++;
        done_c = c;
      end
    end
    check("st_more_pops", 32'(pops), 32'd1);
    check("st_done_cnt", 32'(done_n), 32'd1);
    check("st_done_cycle", 32'(done_c), 32'd10);
    check("st_busy_end", 32'(bus.busy), 32'd0);
    check("st_popcnt", 32'(bus.pop_count), 32'd35);
    check("st_fifo_empty", 32'(bus.rempty), 32'd1);

    // Every pushed word delivered once, in order
    bad = 0;
    for (int i = 0; i < exp_n; i++) begin
      if (acc[i] !== exp_w[i]) bad++;
    end
    check("order_count", 32'(acc_n), 32'd35);
    check("order_bad", 32'(bad), 32'd0);

    // Reset mid-stream with a full buffer
    push(8'h60);
    push(8'h61);
    push(8'h62);
    bus.dout_ready = 1'b0;
    bus.stream_en  = 1'b1;
    repeat (3) @(negedge rclk);
    check("mr_full_valid", 32'(bus.dout_valid), 32'd1);
    check("mr_full_rinc", 32'(bus.rinc), 32'd0);
    #2;
    rrst = 1'b1;
    #1;
    check("mr_rinc", 32'(bus.rinc), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_valid", 32'(bus.dout_valid), 32'd0);
    check("mr_dout", 32'(bus.dout), 32'd0);
    check("mr_popcnt", 32'(bus.pop_count), 32'd0);
    check("mr_done", 32'(bus.burst_done), 32'd0);
    bus.stream_en = 1'b0;
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);
    check("mr_after_valid", 32'(bus.dout_valid), 32'd0);
    check("mr_after_popcnt", 32'(bus.pop_count), 32'd0);
    check("mr_after_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
